// File: rtl/noc_pkg.sv
// noc_pkg: shared constants for the leaf/spine uplink.
//   - flit width and destination field positions
//   - default group ID, source counts for the RX merge arbiter
//   - spine_sel(): destination hash picking spine index 0..3 (spine1..spine4)
package noc_pkg;

  localparam int DWIDTH        = 16;
  localparam int DEST_GRP_MSB  = 15;
  localparam int DEST_GRP_LSB  = 12;
  localparam int DEST_LEAF_MSB = 11;
  localparam int DEST_LEAF_LSB = 10;

  localparam logic [3:0] GROUP_ID_DEFAULT = 4'b0010;

  localparam int NUM_SPINES = 4;
  localparam int NUM_SRC    = NUM_SPINES + 1;  // spines 0..3, loopback last
  localparam int LB_SRC     = NUM_SPINES;

  // Equal destinations always hash to the same spine, which keeps
  // per-destination ordering across the fabric.
  function automatic logic [1:0] spine_sel(input logic [3:0] grp, input logic [1:0] leaf);
    return leaf ^ grp[1:0];
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, reset   clock, async active-high reset (empties the FIFO)
//   push, din    write request/data, ignored when full
//   pop          read request, ignored when empty
//   dout         head entry (valid while !empty)
//   full, empty  status
// Pointers carry one wrap bit: full when wrap bits differ and index bits match.
module noc_sync_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, rptr_q;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/leaf_spine_uplink.sv
// leaf_spine_uplink: leaf-side termination of the four spine links.
// TX: local flits -> TX FIFO -> one registered pulse per flit on the spine
//     chosen by destination hash; self-addressed flits go to a loopback FIFO.
// RX: spine strobes -> per-link FIFOs; RX FIFOs plus loopback are merged by a
//     round-robin arbiter into one registered valid/ready output.
// Ports:
//   clk, reset                               clock, async active-high reset
//   local_in_data/valid/ready                flits from leaf crossbar
//   local_out_data/valid/ready               flits to leaf crossbar
//   spineN_out_data/valid (N=1..4)           valid-only pulses to spine N
//   spineN_in_data/valid  (N=1..4)           valid-only strobes from spine N
//   rx_drop_count                            saturating count of RX overflow cycles
module leaf_spine_uplink #(
  parameter logic [3:0] GROUP_ID      = noc_pkg::GROUP_ID_DEFAULT,
  parameter int         LEAF_ID       = 0,
  parameter int         DWIDTH        = noc_pkg::DWIDTH,
  parameter int         TX_FIFO_DEPTH = 8,
  parameter int         RX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] local_in_data,
  input  logic              local_in_valid,
  output logic              local_in_ready,
  output logic [DWIDTH-1:0] local_out_data,
  output logic              local_out_valid,
  input  logic              local_out_ready,
  output logic [DWIDTH-1:0] spine1_out_data,
  output logic              spine1_out_valid,
  output logic [DWIDTH-1:0] spine2_out_data,
  output logic              spine2_out_valid,
  output logic [DWIDTH-1:0] spine3_out_data,
  output logic              spine3_out_valid,
  output logic [DWIDTH-1:0] spine4_out_data,
  output logic              spine4_out_valid,
  input  logic [DWIDTH-1:0] spine1_in_data,
  input  logic              spine1_in_valid,
  input  logic [DWIDTH-1:0] spine2_in_data,
  input  logic              spine2_in_valid,
  input  logic [DWIDTH-1:0] spine3_in_data,
  input  logic              spine3_in_valid,
  input  logic [DWIDTH-1:0] spine4_in_data,
  input  logic              spine4_in_valid,
  output logic [7:0]        rx_drop_count
);

  import noc_pkg::*;

  localparam logic [1:0] LEAF = 2'(LEAF_ID);

  // ---------------- TX path ----------------
  logic [DWIDTH-1:0] tx_head;
  logic              tx_full, tx_empty, tx_push, tx_pop, tx_self;
  logic [1:0]        tx_sel;
  logic              lb_full, lb_empty, lb_push;

  assign tx_push        = local_in_valid && !tx_full;
  assign local_in_ready = !tx_full && !reset;

  noc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(TX_FIFO_DEPTH)) u_tx (
    .clk, .reset, .push(tx_push), .pop(tx_pop), .din(local_in_data),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign tx_self = (tx_head[DEST_GRP_MSB:DEST_GRP_LSB] == GROUP_ID) &&
                   (tx_head[DEST_LEAF_MSB:DEST_LEAF_LSB] == LEAF);
  assign tx_sel  = spine_sel(tx_head[DEST_GRP_MSB:DEST_GRP_LSB],
                             tx_head[DEST_LEAF_MSB:DEST_LEAF_LSB]);
  // A self-addressed head waits in place while loopback is full.
  assign lb_push = !tx_empty && tx_self && !lb_full;
  assign tx_pop  = !tx_empty && (!tx_self || !lb_full);

  logic [NUM_SPINES-1:0]             sp_vld_q, sp_vld_d;
  logic [NUM_SPINES-1:0][DWIDTH-1:0] sp_dat_q, sp_dat_d;

  always_comb begin
    sp_vld_d = '0;
    sp_dat_d = sp_dat_q;  // data holds between pulses
    if (tx_pop && !tx_self) begin
      sp_vld_d[tx_sel] = 1'b1;
      sp_dat_d[tx_sel] = tx_head;
    end
  end

  // ---------------- RX path ----------------
  logic [NUM_SPINES-1:0][DWIDTH-1:0] sp_in_data;
  logic [NUM_SPINES-1:0]             sp_in_vld, rx_full, rx_empty;
  logic [NUM_SRC-1:0][DWIDTH-1:0]    src_data;
  logic [NUM_SRC-1:0]                src_empty, src_pop;

  assign sp_in_data = {spine4_in_data, spine3_in_data, spine2_in_data, spine1_in_data};
  assign sp_in_vld  = {spine4_in_valid, spine3_in_valid, spine2_in_valid, spine1_in_valid};

  for (genvar n = 0; n < NUM_SPINES; n++) begin : g_rx
    noc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(RX_FIFO_DEPTH)) u_rx (
      .clk, .reset, .push(sp_in_vld[n]), .pop(src_pop[n]), .din(sp_in_data[n]),
      .dout(src_data[n]), .full(rx_full[n]), .empty(rx_empty[n])
    );
  end

  noc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(RX_FIFO_DEPTH)) u_lb (
    .clk, .reset, .push(lb_push), .pop(src_pop[LB_SRC]), .din(tx_head),
    .dout(src_data[LB_SRC]), .full(lb_full), .empty(lb_empty)
  );

  assign src_empty = {lb_empty, rx_empty};

  // Overflow on any number of links in one cycle counts once.
  logic       rx_drop_any;
  logic [7:0] drop_q, drop_d;

  assign rx_drop_any = |(sp_in_vld & rx_full);
  assign drop_d      = (rx_drop_any && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  // Round-robin: first non-empty source at or after rr_q, wrapping 4 -> 0.
  logic       grant_vld, load;
  logic [2:0] grant, rr_q, rr_d;
  logic [3:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      if (!grant_vld && !src_empty[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[2:0];
      end
    end
  end

  logic              out_vld_q, out_vld_d;
  logic [DWIDTH-1:0] out_dat_q, out_dat_d;

  // Reload when empty or being consumed: sustains one flit per cycle.
  assign load = !out_vld_q || local_out_ready;

  always_comb begin
    src_pop   = '0;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    rr_d      = rr_q;
    if (load) begin
      out_vld_d = grant_vld;
      if (grant_vld) begin
        src_pop[grant] = 1'b1;
        out_dat_d      = src_data[grant];
        rr_d           = (grant == 3'(LB_SRC)) ? 3'd0 : grant + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_vld_q  <= '0;
      sp_dat_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      rr_q      <= '0;
      drop_q    <= '0;
    end else begin
      sp_vld_q  <= sp_vld_d;
      sp_dat_q  <= sp_dat_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      rr_q      <= rr_d;
      drop_q    <= drop_d;
    end
  end

  assign local_out_valid  = out_vld_q;
  assign local_out_data   = out_dat_q;
  assign rx_drop_count    = drop_q;
  assign spine1_out_valid = sp_vld_q[0];
  assign spine2_out_valid = sp_vld_q[1];
  assign spine3_out_valid = sp_vld_q[2];
  assign spine4_out_valid = sp_vld_q[3];
  assign spine1_out_data  = sp_dat_q[0];
  assign spine2_out_data  = sp_dat_q[1];
  assign spine3_out_data  = sp_dat_q[2];
  assign spine4_out_data  = sp_dat_q[3];

endmodule

// File: tb/tb_leaf_spine_uplink.sv
// Testbench for leaf_spine_uplink: queue-based reference model feeding
// scoreboards for spine pulses and local output, checked by a monitor.
module tb_leaf_spine_uplink;

  localparam int         TXD  = 8;
  localparam int         RXD  = 4;
  localparam logic [3:0] GRP  = 4'h2;
  localparam logic [1:0] LEAF = 2'd0;

  logic        clk, reset;
  logic [15:0] local_in_data, local_out_data;
  logic        local_in_valid, local_in_ready, local_out_valid, local_out_ready;
  logic [15:0] so_d [4];
  logic        so_v [4];
  logic [15:0] si_d [4];
  logic        si_v [4];
  logic [7:0]  rx_drop_count;

  leaf_spine_uplink #(
    .GROUP_ID(GRP), .LEAF_ID(0), .DWIDTH(16), .TX_FIFO_DEPTH(TXD), .RX_FIFO_DEPTH(RXD)
  ) dut (
    .clk(clk), .reset(reset),
    .local_in_data(local_in_data), .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
    .local_out_data(local_out_data), .local_out_valid(local_out_valid), .local_out_ready(local_out_ready),
    .spine1_out_data(so_d[0]), .spine1_out_valid(so_v[0]),
    .spine2_out_data(so_d[1]), .spine2_out_valid(so_v[1]),
    .spine3_out_data(so_d[2]), .spine3_out_valid(so_v[2]),
    .spine4_out_data(so_d[3]), .spine4_out_valid(so_v[3]),
    .spine1_in_data(si_d[0]), .spine1_in_valid(si_v[0]),
    .spine2_in_data(si_d[1]), .spine2_in_valid(si_v[1]),
    .spine3_in_data(si_d[2]), .spine3_in_valid(si_v[2]),
    .spine4_in_data(si_d[3]), .spine4_in_valid(si_v[3]),
    .rx_drop_count(rx_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [2:0] sp; logic [15:0] d; int c; } tx_exp_t;
  tx_exp_t     exp_tx[$];   // expected spine pulses (spine number, data, cycle)
  logic [15:0] exp_out[$];  // expected local_out flits in delivery order

  logic [15:0] m_tx[$];
  logic [15:0] m_lb[$];
  logic [15:0] m_rx[4][$];
  logic        m_ov;
  logic [15:0] m_od;
  int          m_rr, m_drops;

  task automatic model_clear();
    m_tx.delete(); m_lb.delete();
    for (int n = 0; n < 4; n++) m_rx[n].delete();
    exp_tx.delete(); exp_out.delete();
    m_ov = 1'b0; m_od = '0; m_rr = 0; m_drops = 0;
  endtask

  function automatic int src_size(input int s);
    return (s == 4) ? m_lb.size() : m_rx[s].size();
  endfunction

  // Advance the model across the coming clock edge using current inputs.
  task automatic model_step();
    int tx_sz, lb_sz, g;
    int rx_sz[4];
    bit dropped;
    logic [15:0] h;
    if (reset) return;
    tx_sz = m_tx.size();
    lb_sz = m_lb.size();
    for (int n = 0; n < 4; n++) rx_sz[n] = m_rx[n].size();
    // merge arbiter
    if (!m_ov || local_out_ready) begin
      g = -1;
      for (int i = 0; i < 5; i++)
        if (g < 0 && src_size((m_rr + i) % 5) > 0) g = (m_rr + i) % 5;
      if (g >= 0) begin
        m_od = (g == 4) ? m_lb.pop_front() : m_rx[g].pop_front();
        m_ov = 1'b1;
        m_rr = (g + 1) % 5;
        exp_out.push_back(m_od);
      end else m_ov = 1'b0;
    end
    // TX dispatch from head
    if (tx_sz > 0) begin
      h = m_tx[0];
      if (h[15:12] == GRP && h[11:10] == LEAF) begin
        if (lb_sz < RXD) begin
          m_lb.push_back(h);
          void'(m_tx.pop_front());
        end
      end else begin
        exp_tx.push_back('{sp: 3'(h[11:10] ^ h[13:12]) + 3'd1, d: h, c: cyc + 1});
        void'(m_tx.pop_front());
      end
    end
    if (local_in_valid && tx_sz < TXD) m_tx.push_back(local_in_data);
    dropped = 1'b0;
    for (int n = 0; n < 4; n++)
      if (si_v[n]) begin
        if (rx_sz[n] < RXD) m_rx[n].push_back(si_d[n]);
        else dropped = 1'b1;
      end
    if (dropped && m_drops < 255) m_drops++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    tx_exp_t     e;
    logic [15:0] eo;
    int          nv;
    if (reset) model_clear();
    chk("in_ready", 32'(local_in_ready), 32'(!reset && m_tx.size() < TXD));
    chk("out_valid", 32'(local_out_valid), 32'(m_ov));
    if (m_ov) chk("out_data", 32'(local_out_data), 32'(m_od));
    if (local_out_valid && local_out_ready) begin
      if (exp_out.size() == 0) chk("out_unexpected", 32'(local_out_data), 32'hFFFF_FFFF);
      else begin
        eo = exp_out.pop_front();
        chk("out_sb", 32'(local_out_data), 32'(eo));
      end
    end
    nv = 0;
    for (int n = 0; n < 4; n++) if (so_v[n]) nv++;
    chk("spine_onehot", 32'(nv <= 1), 32'd1);
    for (int n = 0; n < 4; n++) begin
      if (so_v[n]) begin
        if (exp_tx.size() == 0) chk("spine_unexpected", 32'(n + 1), 32'd0);
        else begin
          e = exp_tx.pop_front();
          chk("spine_idx", 32'(n + 1), 32'(e.sp));
          chk("spine_data", 32'(so_d[n]), 32'(e.d));
          chk("spine_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
    while (exp_tx.size() > 0 && exp_tx[0].c <= cyc) begin
      e = exp_tx.pop_front();
      chk("spine_missing", 32'(e.d), 32'hFFFF_FFFF);
    end
    chk("drop_count", 32'(rx_drop_count), 32'(m_drops));
    if (reset) chk("reset_spine_data", {so_d[0] | so_d[1], so_d[2] | so_d[3]}, 32'd0);
    model_step();
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    local_in_valid = 1'b0;
    for (int n = 0; n < 4; n++) si_v[n] = 1'b0;
  endtask

  logic [15:0] sweep [4];

  initial begin
    reset = 1'b1;
    local_in_data = '0;
    local_out_ready = 1'b1;
    for (int n = 0; n < 4; n++) si_d[n] = '0;
    idle_inputs();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // single flit to spine1
    local_in_data = 16'h3D05; local_in_valid = 1'b1;
    tick();
    idle_inputs();
    repeat (5) tick();

    // spine hash sweep, back to back
    sweep[0] = 16'h1000; sweep[1] = 16'h1400; sweep[2] = 16'h1800; sweep[3] = 16'h1C00;
    for (int i = 0; i < 4; i++) begin
      local_in_data = sweep[i]; local_in_valid = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    // TX full via loopback stall
    local_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      local_in_data = 16'h2000 | 16'(i); local_in_valid = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    local_out_ready = 1'b1;
    repeat (30) tick();

    // RX overflow on spine3
    local_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      si_v[2] = 1'b1; si_d[2] = 16'hA000 | 16'(i);
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    local_out_ready = 1'b1;
    repeat (10) tick();

    // fairness: all spines every cycle, occasional stalls
    for (int i = 0; i < 24; i++) begin
      for (int n = 0; n < 4; n++) begin
        si_v[n] = 1'b1;
        si_d[n] = 16'(((8 + n) << 12) | i);
      end
      local_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    local_out_ready = 1'b1;
    repeat (20) tick();

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      local_in_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) local_in_data = {GRP, LEAF, 10'($urandom)};
      else local_in_data = 16'($urandom);
      for (int n = 0; n < 4; n++) begin
        si_v[n] = ($urandom_range(0, 9) < 3);
        si_d[n] = 16'($urandom);
      end
      local_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    local_out_ready = 1'b1;
    repeat (30) tick();

    // reset with traffic buffered
    local_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      local_in_valid = 1'b1;
      local_in_data = (i % 2 == 0) ? (16'h2000 | 16'(i)) : (16'h5400 | 16'(i));
      si_v[i % 4] = 1'b1; si_d[i % 4] = 16'hB000 | 16'(i);
      tick();
      for (int n = 0; n < 4; n++) si_v[n] = 1'b0;
    end
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    local_out_ready = 1'b1;
    repeat (15) tick();

    chk("tx_sb_drained", 32'(exp_tx.size()), 32'd0);
    chk("out_sb_drained", 32'(exp_out.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
